stopwatch_ctrl: RTL and testbench

//  Control FSM that sequences a cascade of 4-bit up-counter slices (binary, async active-high Rst, En/Carry3 chain).

---
 rtl/stopwatch_ctrl_pkg.sv | 19 +
 rtl/stopwatch_ctrl_if.sv | 33 +++
 rtl/stopwatch_ctrl_tick_gen.sv | 43 ++++
 rtl/stopwatch_ctrl.sv | 150 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller and its display mux.
//   sw_state_e : 3-bit FSM state encoding (IDLE, RUN, PAUSE, LAP, HALT)
//   cnt_width(): counter/display width from the number of 4-bit slices
// HALT is only reachable when OVERFLOW_HALT_EN is defined.
package stopwatch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_HALT  = 3'd4
  } sw_state_e;

  function automatic int unsigned cnt_width(input int unsigned digits);
    return 4 * digits;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the button/datapath side (master) and the
// stopwatch controller (slave).
//   Start_Stop, Lap, Clear : 1-cycle debounced button pulses
//   Count_In, Carry_In     : live cascade value and top-slice Carry3
//   Cnt_En, Cnt_Rst        : registered enable / clear to the cascade
//   Display_Val            : live or lap-frozen value for display
//   Running, Overflow      : status flags
interface stopwatch_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             Start_Stop;
  logic             Lap;
  logic             Clear;
  logic [CNT_W-1:0] Count_In;
  logic             Carry_In;
  logic             Cnt_En;
  logic             Cnt_Rst;
  logic [CNT_W-1:0] Display_Val;
  logic             Running;
  logic             Overflow;

  modport master (
    output Start_Stop, Lap, Clear, Count_In, Carry_In,
    input  Cnt_En, Cnt_Rst, Display_Val, Running, Overflow
  );

  modport slave (
    input  Start_Stop, Lap, Clear, Count_In, Carry_In,
    output Cnt_En, Cnt_Rst, Display_Val, Running, Overflow
  );

endinterface

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Prescaler for the stopwatch count enable.
//   Clk, Rst_n : clock, synchronous active-low reset
//   run        : advance the prescaler this cycle
//   clr        : zero the prescaler (wins over run)
//   tick       : combinational terminal detect (run && prescaler == PRESCALE-1)
// The counter wraps to 0 on the terminal cycle; it holds when run is low.
module stopwatch_ctrl_tick_gen #(
  parameter int unsigned PRESCALE = 100000
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] TERM = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          at_term;

  assign at_term = (pre_q == TERM);
  assign tick    = run && at_term;

  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (run) begin
      pre_d = at_term ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM driving a cascade of 4-bit counter slices.
//   Clk, Rst_n : clock, synchronous active-low reset
//   bus        : stopwatch_ctrl_if.slave (buttons, cascade value/carry in;
//                Cnt_En, Cnt_Rst, Display_Val, Running, Overflow out)
// Parameters: PRESCALE (clocks per count tick, >=2), DIGITS (4-bit slices).
// Optional macro OVERFLOW_HALT_EN: stop in HALT at all-ones instead of
// wrapping the cascade.
// Button priority: Clear > Start_Stop > Lap; only an event accepted in the
// current state pre-empts the lower-priority ones.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned DIGITS   = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  stopwatch_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(DIGITS);

  sw_state_e        state_q, state_d;
  logic             cnt_en_q, cnt_en_d;
  logic             cnt_rst_q, cnt_rst_d;
  logic [CNT_W-1:0] disp_q, disp_d;
  logic             running_q, running_d;
  logic             ovf_q, ovf_d;
  logic             frz_q, frz_d;     // PAUSE entered from LAP: keep display frozen

  logic             presc_run;
  logic             presc_clr;
  logic             tick;

  // Prescaler advances only while counting continues; a Start_Stop in
  // RUN/LAP holds it so a pending tick is suppressed and resumes later.
  assign presc_run = ((state_q == ST_RUN) || (state_q == ST_LAP)) && !bus.Start_Stop;
  assign presc_clr = (state_q == ST_IDLE) || (state_q == ST_HALT) ||
                     ((state_q == ST_PAUSE) && bus.Clear);

  stopwatch_ctrl_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .run   (presc_run),
    .clr   (presc_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    cnt_en_d  = 1'b0;
    cnt_rst_d = 1'b0;
    frz_d     = frz_q;
    ovf_d     = ovf_q | (cnt_en_q & bus.Carry_In);

    case (state_q)
      ST_IDLE: begin
        if (bus.Clear) begin
          cnt_rst_d = 1'b1;
          ovf_d     = 1'b0;
        end else if (bus.Start_Stop) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.Start_Stop) begin
          state_d = ST_PAUSE;
          frz_d   = 1'b0;
        end else if (bus.Lap) begin
          state_d = ST_LAP;
        end
      end
      ST_LAP: begin
        if (bus.Start_Stop) begin
          state_d = ST_PAUSE;
          frz_d   = 1'b1;
        end else if (bus.Lap) begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (bus.Clear) begin
          state_d   = ST_IDLE;
          cnt_rst_d = 1'b1;
          ovf_d     = 1'b0;
          frz_d     = 1'b0;
        end else if (bus.Start_Stop) begin
          state_d = ST_RUN;
          frz_d   = 1'b0;
        end
      end
      ST_HALT: begin
        if (bus.Clear) begin
          state_d   = ST_IDLE;
          cnt_rst_d = 1'b1;
          ovf_d     = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (tick) begin
`ifdef OVERFLOW_HALT_EN
      if (&bus.Count_In) begin
        state_d = ST_HALT;
        ovf_d   = 1'b1;
      end else begin
        cnt_en_d = 1'b1;
      end
`else
      cnt_en_d = 1'b1;
`endif
    end

    disp_d    = ((state_q == ST_LAP) || ((state_q == ST_PAUSE) && frz_q)) ?
                disp_q : bus.Count_In;
    running_d = (state_d == ST_RUN) || (state_d == ST_LAP);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      cnt_en_q  <= 1'b0;
      cnt_rst_q <= 1'b1;
      disp_q    <= '0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
      frz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_en_q  <= cnt_en_d;
      cnt_rst_q <= cnt_rst_d;
      disp_q    <= disp_d;
      running_q <= running_d;
      ovf_q     <= ovf_d;
      frz_q     <= frz_d;
    end
  end

  assign bus.Cnt_En      = cnt_en_q;
  assign bus.Cnt_Rst     = cnt_rst_q;
  assign bus.Display_Val = disp_q;
  assign bus.Running     = running_q;
  assign bus.Overflow    = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with PRESCALE=4, DIGITS=1 and a
// behavioural 4-bit counter slice standing in for the cascade.
module tb_stopwatch_ctrl;

  logic       Clk;
  logic       Rst_n;
  logic [3:0] count;

  stopwatch_ctrl_if #(.CNT_W(4)) sw_if ();

  stopwatch_ctrl #(
    .PRESCALE (4),
    .DIGITS   (1)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (sw_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // 4-bit slice: async active-high reset, count on enable, Carry3 combinational
  always @(posedge Clk or posedge sw_if.Cnt_Rst) begin
    if (sw_if.Cnt_Rst) count <= 4'd0;
    else if (sw_if.Cnt_En) count <= count + 4'd1;
  end
  assign sw_if.Count_In = count;
  assign sw_if.Carry_In = sw_if.Cnt_En & (count == 4'hF);

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    string       name;
    logic        ss, lp, cl;   // pulse applied on the first cycle only
    int unsigned n;            // cycles before checking
    logic        en, rst;
    logic [3:0]  disp;
    logic        run, ovf;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[15];

  task automatic cyc(input logic ss, input logic lp, input logic cl);
    @(negedge Clk);
    sw_if.Start_Stop = ss;
    sw_if.Lap        = lp;
    sw_if.Clear      = cl;
    @(posedge Clk);
    #1;
  endtask

  task automatic run_n(input logic ss, input logic lp, input logic cl, input int unsigned n);
    cyc(ss, lp, cl);
    for (int unsigned i = 1; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic en, input logic rst, input logic [3:0] disp,
                     input logic run, input logic ovf, input logic [3:0] cnt);
    total++;
    if ({sw_if.Cnt_En, sw_if.Cnt_Rst, sw_if.Display_Val, sw_if.Running, sw_if.Overflow, count}
        !== {en, rst, disp, run, ovf, cnt}) begin
      bad++;
      $display("FAIL %s: got en=%b rst=%b disp=%0d run=%b ovf=%b cnt=%0d; required en=%b rst=%b disp=%0d run=%b ovf=%b cnt=%0d",
               name, sw_if.Cnt_En, sw_if.Cnt_Rst, sw_if.Display_Val, sw_if.Running, sw_if.Overflow, count,
               en, rst, disp, run, ovf, cnt);
    end
  endtask

  initial begin
    //          name       ss   lp   cl   n   en   rst  disp run  ovf  cnt
    tbl[0]  = '{"start",    1'b1,1'b0,1'b0, 1, 1'b0,1'b0,4'd0, 1'b1,1'b0,4'd0};
    tbl[1]  = '{"tick1",    1'b0,1'b0,1'b0, 4, 1'b1,1'b0,4'd0, 1'b1,1'b0,4'd0};
    tbl[2]  = '{"inc1",     1'b0,1'b0,1'b0, 1, 1'b0,1'b0,4'd0, 1'b1,1'b0,4'd1};
    tbl[3]  = '{"run20",    1'b0,1'b0,1'b0,16, 1'b0,1'b0,4'd4, 1'b1,1'b0,4'd5};
    tbl[4]  = '{"to9",      1'b0,1'b0,1'b0,16, 1'b0,1'b0,4'd8, 1'b1,1'b0,4'd9};
    tbl[5]  = '{"lap_cap",  1'b0,1'b1,1'b0, 1, 1'b0,1'b0,4'd9, 1'b1,1'b0,4'd9};
    tbl[6]  = '{"lap_hold", 1'b0,1'b0,1'b0,12, 1'b0,1'b0,4'd9, 1'b1,1'b0,4'd12};
    tbl[7]  = '{"lap_exit", 1'b0,1'b1,1'b0, 1, 1'b0,1'b0,4'd9, 1'b1,1'b0,4'd12};
    tbl[8]  = '{"live",     1'b0,1'b0,1'b0, 1, 1'b1,1'b0,4'd12,1'b1,1'b0,4'd12};
    tbl[9]  = '{"clr_ign",  1'b0,1'b0,1'b1, 3, 1'b0,1'b0,4'd13,1'b1,1'b0,4'd13};
    tbl[10] = '{"pause_pn", 1'b1,1'b0,1'b0, 1, 1'b0,1'b0,4'd13,1'b0,1'b0,4'd13};
    tbl[11] = '{"paused",   1'b0,1'b1,1'b0,10, 1'b0,1'b0,4'd13,1'b0,1'b0,4'd13};
    tbl[12] = '{"resume",   1'b1,1'b0,1'b0, 1, 1'b0,1'b0,4'd13,1'b1,1'b0,4'd13};
    tbl[13] = '{"rem_tick", 1'b0,1'b0,1'b0, 1, 1'b1,1'b0,4'd13,1'b1,1'b0,4'd13};
    tbl[14] = '{"rem_inc",  1'b0,1'b0,1'b0, 1, 1'b0,1'b0,4'd13,1'b1,1'b0,4'd14};

    sw_if.Start_Stop = 1'b0;
    sw_if.Lap        = 1'b0;
    sw_if.Clear      = 1'b0;
    Rst_n            = 1'b0;

    // Reset held for two edges
    repeat (2) @(posedge Clk);
    #1;
    chk("reset", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst_release", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);

    for (int unsigned i = 0; i < 15; i++) begin
      run_n(tbl[i].ss, tbl[i].lp, tbl[i].cl, tbl[i].n);
      chk(tbl[i].name, tbl[i].en, tbl[i].rst, tbl[i].disp, tbl[i].run, tbl[i].ovf, tbl[i].cnt);
    end

    // Count past 15
    run_n(1'b0, 1'b0, 1'b0, 7);
`ifdef OVERFLOW_HALT_EN
    chk("halt_enter", 1'b0, 1'b0, 4'd15, 1'b0, 1'b1, 4'd15);
    run_n(1'b0, 1'b0, 1'b0, 4);
    chk("halt_hold", 1'b0, 1'b0, 4'd15, 1'b0, 1'b1, 4'd15);
    cyc(1'b1, 1'b1, 1'b0);
    chk("halt_ign", 1'b0, 1'b0, 4'd15, 1'b0, 1'b1, 4'd15);
    cyc(1'b0, 1'b0, 1'b1);
    chk("halt_clr", 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 4'd0);
`else
    chk("wrap_tick", 1'b1, 1'b0, 4'd15, 1'b1, 1'b0, 4'd15);
    cyc(1'b0, 1'b0, 1'b0);
    chk("wrap_ovf", 1'b0, 1'b0, 4'd15, 1'b1, 1'b1, 4'd0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("ovf_pause", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0);
`endif
    cyc(1'b0, 1'b0, 1'b0);
    chk("rst_pulse1", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);

    // Lap -> pause keeps display frozen; Clear beats Start_Stop in PAUSE
    cyc(1'b1, 1'b0, 1'b0);
    run_n(1'b0, 1'b0, 1'b0, 5);
    chk("f_run", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1);
    cyc(1'b0, 1'b1, 1'b0);
    run_n(1'b0, 1'b0, 1'b0, 3);
    chk("f_lap", 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 4'd2);
    cyc(1'b1, 1'b0, 1'b0);
    run_n(1'b0, 1'b0, 1'b0, 3);
    chk("f_pause_frz", 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 4'd2);
    cyc(1'b1, 1'b0, 1'b1);
    chk("clr_wins", 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("clr_live", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    run_n(1'b0, 1'b0, 1'b0, 5);
    chk("start_dropped", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);

    // Reset in the middle of counting
    cyc(1'b1, 1'b0, 1'b0);
    run_n(1'b0, 1'b0, 1'b0, 5);
    chk("g_run", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1);
    @(negedge Clk);
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    chk("mid_reset", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
